// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter (and the future receiver).
// - tx_state_e : FSM state encoding, IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
// - LINE_IDLE  : level of an idle serial line
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter, clock-enabled by baud_tick from the divider stage.
// Sends start bit, DATA_BITS data bits LSB first, optional parity bit and
// STOP_BITS stop bits. A one-entry holding register lets the next byte be
// accepted while the current frame shifts out; back-to-back frames have no
// idle gap.
// Ports:
//   clk       system clock, all state changes on rising edge
//   reset     synchronous, active-high
//   baud_tick one-clk pulse per bit period
//   tx_data   byte to send, sampled when tx_valid && tx_ready
//   tx_valid  tx_data is valid
//   tx_ready  holding register empty (independent of tx_valid)
//   tx        registered serial line, idle high
//   tx_busy   registered, high while the FSM is not IDLE
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_e state_q, state_d;

  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 parity_q, parity_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic xfer;
  logic load;
  logic stop_last;

  assign tx_ready = !hold_full_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;

  // Load and transfer are mutually exclusive: a load needs hold_full,
  // a transfer needs it clear.
  always_comb begin
    xfer      = tx_valid && !hold_full_q;
    stop_last = (state_q == STOP) && (stop_cnt_q == STOP_LAST);
    load      = baud_tick && hold_full_q && ((state_q == IDLE) || stop_last);
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      parity_q    <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= LINE_IDLE;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      parity_q    <= parity_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic, advancing only on baud_tick.
  always_comb begin
    state_d = state_q;
    if (baud_tick) begin
      unique case (state_q)
        IDLE:   if (hold_full_q) state_d = START;
        START:  state_d = DATA;
        DATA: begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: state_d = STOP;
        STOP: begin
          if (stop_cnt_q == STOP_LAST) begin
            state_d = hold_full_q ? START : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath and output logic.
  always_comb begin
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    parity_d    = parity_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    tx_d        = tx_q;
    busy_d      = (state_d != IDLE);

    if (xfer) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Parity is taken from the byte as loaded, since shift_q is consumed
    // while the data bits go out.
    if (load) begin
      shift_d     = hold_q;
      parity_d    = (^hold_q) ^ 1'(PARITY_ODD);
      hold_full_d = 1'b0;
    end

    if (baud_tick) begin
      unique case (state_q)
        IDLE: tx_d = load ? 1'b0 : LINE_IDLE;
        START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
        end
        DATA: begin
          if (bit_cnt_q < BIT_LAST) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = shift_q[1];
          end else if (PARITY_EN != 0) begin
            tx_d = parity_q;
          end else begin
            tx_d       = LINE_IDLE;
            stop_cnt_d = 1'b0;
          end
        end
        PARITY: begin
          tx_d       = LINE_IDLE;
          stop_cnt_d = 1'b0;
        end
        STOP: begin
          if (stop_cnt_q < STOP_LAST) begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            tx_d       = LINE_IDLE;
          end else begin
            tx_d = load ? 1'b0 : LINE_IDLE;
          end
        end
        default: tx_d = LINE_IDLE;
      endcase
    end
  end

endmodule
